// File: rtl/datapath_sequencer_if.sv
// Command and datapath-control bundle for datapath_sequencer.
//   master : command source side (drives cmd_*, observes controls/done/err)
//   slave  : sequencer side (accepts cmd_*, drives cmd_ready, controls, done/err)
//   cmd_*       : valid/ready command channel (op, rd, rn, rm, shift, imm8)
//   readnum..loads : datapath control signals
//   datapath_in : extended MOVI immediate, W bits
//   done/err    : completion pulse and illegal-opcode flag
interface datapath_sequencer_if #(parameter int W = 16);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_rd;
  logic [2:0]   cmd_rn;
  logic [2:0]   cmd_rm;
  logic [1:0]   cmd_shift;
  logic [7:0]   cmd_imm8;
  logic [2:0]   readnum;
  logic [2:0]   writenum;
  logic         write;
  logic         vsel;
  logic         loada;
  logic         loadb;
  logic [1:0]   shift;
  logic         asel;
  logic         bsel;
  logic [1:0]   ALUop;
  logic         loadc;
  logic         loads;
  logic [W-1:0] datapath_in;
  logic         done;
  logic         err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm8,
    input  cmd_ready, readnum, writenum, write, vsel, loada, loadb, shift,
           asel, bsel, ALUop, loadc, loads, datapath_in, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm8,
    output cmd_ready, readnum, writenum, write, vsel, loada, loadb, shift,
           asel, bsel, ALUop, loadc, loads, datapath_in, done, err
  );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: steps the lab datapath through register read, execute
// and writeback for one command per valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : datapath_sequencer_if.slave (command channel, datapath
//                controls, datapath_in, done/err)
// All controls are registered and decoded from the next state plus the
// latched command, so they change exactly with the state register.
module datapath_sequencer #(
  parameter int W        = 16,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  datapath_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WRITE, S_DONE
  } state_t;

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_CMP  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVN  = 3'd5;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    logic [1:0] shift;
  } cmd_t;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic [1:0] shift;
    logic       asel;
    logic       bsel;
    logic [1:0] aluop;
    logic       loadc;
    logic       loads;
    logic       done;
    logic       err;
  } ctrl_t;

  state_t       state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  ctrl_t        ctrl_q, ctrl_d;
  logic [W-1:0] dp_q, dp_d;
  logic [W-1:0] imm_ext;

  assign imm_ext = IMM_SEXT ? {{(W-8){bus.cmd_imm8[7]}}, bus.cmd_imm8}
                            : {{(W-8){1'b0}}, bus.cmd_imm8};

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dp_d    = dp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d = '{op: bus.cmd_op, rd: bus.cmd_rd, rn: bus.cmd_rn,
                    rm: bus.cmd_rm, shift: bus.cmd_shift};
          dp_d  = imm_ext;
          case (bus.cmd_op)
            OP_MOVI:                 state_d = S_WRITE;
            OP_MOV, OP_MVN:          state_d = S_LOAD_B;
            OP_ADD, OP_AND, OP_CMP:  state_d = S_LOAD_A;
            default:                 state_d = S_DONE;   // illegal opcode
          endcase
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = (cmd_q.op == OP_CMP) ? S_DONE : S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore decode on the upcoming state so outputs register alongside it.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_LOAD_A: begin
        ctrl_d.readnum = cmd_d.rn;
        ctrl_d.loada   = 1'b1;
      end
      S_LOAD_B: begin
        ctrl_d.readnum = cmd_d.rm;
        ctrl_d.loadb   = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.shift = cmd_d.shift;
        ctrl_d.asel  = (cmd_d.op == OP_MOV) || (cmd_d.op == OP_MVN);
        case (cmd_d.op)
          OP_CMP:  ctrl_d.aluop = 2'b01;
          OP_AND:  ctrl_d.aluop = 2'b10;
          OP_MVN:  ctrl_d.aluop = 2'b11;
          default: ctrl_d.aluop = 2'b00;
        endcase
        ctrl_d.loadc = (cmd_d.op != OP_CMP);
        ctrl_d.loads = (cmd_d.op == OP_CMP);
      end
      S_WRITE: begin
        ctrl_d.writenum = cmd_d.rd;
        ctrl_d.write    = 1'b1;
        ctrl_d.vsel     = (cmd_d.op == OP_MOVI);
      end
      S_DONE: begin
        ctrl_d.done = 1'b1;
        ctrl_d.err  = (cmd_d.op[2:1] == 2'b11);
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ctrl_q  <= '0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ctrl_q  <= ctrl_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.readnum     = ctrl_q.readnum;
  assign bus.writenum    = ctrl_q.writenum;
  assign bus.write       = ctrl_q.write;
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.loada       = ctrl_q.loada;
  assign bus.loadb       = ctrl_q.loadb;
  assign bus.shift       = ctrl_q.shift;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.ALUop       = ctrl_q.aluop;
  assign bus.loadc       = ctrl_q.loadc;
  assign bus.loads       = ctrl_q.loads;
  assign bus.done        = ctrl_q.done;
  assign bus.err         = ctrl_q.err;
  assign bus.datapath_in = dp_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: table of commands with expected
// latency/err/datapath_in, a per-cycle expected-control queue built from the
// command semantics, plus hand sequences for held-valid and mid-command reset.
module tb_datapath_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  datapath_sequencer_if #(.W(W)) bus();
  datapath_sequencer #(.W(W), .IMM_SEXT(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic         ready;
    logic [2:0]   readnum;
    logic [2:0]   writenum;
    logic         write;
    logic         vsel;
    logic         loada;
    logic         loadb;
    logic [1:0]   shift;
    logic         asel;
    logic         bsel;
    logic [1:0]   aluop;
    logic         loadc;
    logic         loads;
    logic         done;
    logic         err;
    logic [W-1:0] dp;
  } obs_t;

  typedef struct {
    logic [2:0]   op;
    logic [2:0]   rd;
    logic [2:0]   rn;
    logic [2:0]   rm;
    logic [1:0]   sh;
    logic [7:0]   imm;
    int           lat;
    logic         err;
    logic [W-1:0] dp;
  } vec_t;

  localparam int ST_LA = 0, ST_LB = 1, ST_EX = 2, ST_WR = 3, ST_DN = 4, ST_ID = 5;

  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  vec_t vecs[9];

  function automatic obs_t sample();
    obs_t a;
    a.ready = bus.cmd_ready;  a.readnum = bus.readnum; a.writenum = bus.writenum;
    a.write = bus.write;      a.vsel = bus.vsel;       a.loada = bus.loada;
    a.loadb = bus.loadb;      a.shift = bus.shift;     a.asel = bus.asel;
    a.bsel = bus.bsel;        a.aluop = bus.ALUop;     a.loadc = bus.loadc;
    a.loads = bus.loads;      a.done = bus.done;       a.err = bus.err;
    a.dp = bus.datapath_in;
    return a;
  endfunction

  // Expected observable outputs for one stage of a command.
  function automatic obs_t model_stage(int stg, vec_t v);
    obs_t e = '0;
    e.dp = {{8{v.imm[7]}}, v.imm};
    case (stg)
      ST_LA: begin e.readnum = v.rn; e.loada = 1'b1; end
      ST_LB: begin e.readnum = v.rm; e.loadb = 1'b1; end
      ST_EX: begin
        e.shift = v.sh;
        e.asel  = (v.op == 3'd1 || v.op == 3'd5);
        e.aluop = (v.op == 3'd3) ? 2'b01 : (v.op == 3'd4) ? 2'b10 :
                  (v.op == 3'd5) ? 2'b11 : 2'b00;
        e.loadc = (v.op != 3'd3);
        e.loads = (v.op == 3'd3);
      end
      ST_WR: begin e.writenum = v.rd; e.write = 1'b1; e.vsel = (v.op == 3'd0); end
      ST_DN: begin e.done = 1'b1; e.err = (v.op >= 3'd6); end
      default: e.ready = 1'b1;
    endcase
    return e;
  endfunction

  task automatic push_trace(vec_t v);
    case (v.op)
      3'd0: exp_q.push_back(model_stage(ST_WR, v));
      3'd1, 3'd5: begin
        exp_q.push_back(model_stage(ST_LB, v));
        exp_q.push_back(model_stage(ST_EX, v));
        exp_q.push_back(model_stage(ST_WR, v));
      end
      3'd2, 3'd4: begin
        exp_q.push_back(model_stage(ST_LA, v));
        exp_q.push_back(model_stage(ST_LB, v));
        exp_q.push_back(model_stage(ST_EX, v));
        exp_q.push_back(model_stage(ST_WR, v));
      end
      3'd3: begin
        exp_q.push_back(model_stage(ST_LA, v));
        exp_q.push_back(model_stage(ST_LB, v));
        exp_q.push_back(model_stage(ST_EX, v));
      end
      default: ;
    endcase
    exp_q.push_back(model_stage(ST_DN, v));
    exp_q.push_back(model_stage(ST_ID, v));
  endtask

  task automatic cmp(string nm, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic cmp_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  task automatic drive(vec_t v);
    bus.cmd_op = v.op; bus.cmd_rd = v.rd; bus.cmd_rn = v.rn;
    bus.cmd_rm = v.rm; bus.cmd_shift = v.sh; bus.cmd_imm8 = v.imm;
  endtask

  task automatic send(string nm, vec_t v, bit hold);
    int ok = 0;
    @(negedge clk);
    drive(v);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    cmp_int({nm, "_accept"}, ok, 1);
    if (ok == 1) begin
      push_trace(v);
      @(posedge clk);
      if (!hold) #1 bus.cmd_valid = 1'b0;
    end else begin
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic check_trace(string nm, vec_t v, bit chg, vec_t nxt);
    int   idx = 0;
    int   done_at = -1;
    int   err_at = 0;
    int   dp_at = 0;
    obs_t e, a;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = sample();
      idx++;
      cmp($sformatf("%s_c%0d", nm, idx), a, e);
      if (a.done && done_at < 0) begin
        done_at = idx; err_at = int'(a.err); dp_at = int'(a.dp);
      end
      if (chg && exp_q.size() > 0) drive(nxt);
    end
    cmp_int({nm, "_latency"}, done_at, v.lat);
    cmp_int({nm, "_err"}, err_at, int'(v.err));
    cmp_int({nm, "_dp"}, dp_at, int'(v.dp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    obs_t rst_exp;
    obs_t a;
    vec_t va, vb;
    int   writes;

    //           op    rd    rn    rm    sh     imm    lat err dp
    vecs[0] = '{3'd0, 3'd3, 3'd0, 3'd0, 2'b00, 8'h05, 2, 1'b0, 16'h0005};
    vecs[1] = '{3'd2, 3'd2, 3'd0, 3'd1, 2'b01, 8'h00, 5, 1'b0, 16'h0000};
    vecs[2] = '{3'd3, 3'd0, 3'd4, 3'd4, 2'b00, 8'h00, 4, 1'b0, 16'h0000};
    vecs[3] = '{3'd5, 3'd7, 3'd0, 3'd6, 2'b00, 8'h00, 4, 1'b0, 16'h0000};
    vecs[4] = '{3'd6, 3'd1, 3'd2, 3'd3, 2'b11, 8'h80, 1, 1'b1, 16'hFF80};
    vecs[5] = '{3'd1, 3'd1, 3'd0, 3'd5, 2'b10, 8'h7F, 4, 1'b0, 16'h007F};
    vecs[6] = '{3'd4, 3'd6, 3'd2, 3'd3, 2'b11, 8'h01, 5, 1'b0, 16'h0001};
    vecs[7] = '{3'd0, 3'd5, 3'd0, 3'd0, 2'b00, 8'h80, 2, 1'b0, 16'hFF80};
    vecs[8] = '{3'd7, 3'd4, 3'd4, 3'd4, 2'b01, 8'hFE, 1, 1'b1, 16'hFFFE};

    rst_exp = '0;
    rst_exp.ready = 1'b1;

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    drive(vecs[0]);
    #12;
    cmp("reset_state", sample(), rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send($sformatf("vec%0d", i), vecs[i], 1'b0);
      check_trace($sformatf("vec%0d", i), vecs[i], 1'b0, vecs[i]);
    end

    // Held valid: second command presented during busy is ignored until the
    // idle cycle after DONE, then accepted.
    va = '{3'd2, 3'd5, 3'd1, 3'd2, 2'b00, 8'h11, 5, 1'b0, 16'h0011};
    vb = '{3'd0, 3'd4, 3'd0, 3'd0, 2'b00, 8'h22, 2, 1'b0, 16'h0022};
    send("held_a", va, 1'b1);
    check_trace("held_a", va, 1'b1, vb);
    push_trace(vb);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    check_trace("held_b", vb, 1'b0, vb);

    // Reset dropped during EXEC of ADD.
    va = '{3'd2, 3'd3, 3'd1, 3'd2, 2'b10, 8'h33, 5, 1'b0, 16'h0033};
    send("rst_add", va, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      cmp($sformatf("rst_add_c%0d", i), sample(), exp_q.pop_front());
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 cmp("rst_async", sample(), rst_exp);
    drive(vecs[7]);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp("rst_no_accept", sample(), rst_exp);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = sample();
      if (a.write) writes++;
    end
    cmp_int("rst_no_write", writes, 0);
    cmp("rst_idle_after", sample(), rst_exp);
    send("post_rst", vecs[0], 1'b0);
    check_trace("post_rst", vecs[0], 1'b0, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
